// File: rtl/lc3_arb_pkg.sv
// Shared types and constants for the LC3 unified-memory arbiter.
package lc3_arb_pkg;

  localparam int unsigned DBURST_W   = 4;
  localparam int unsigned TCNT_W     = 8;
  localparam logic [15:0] ABORT_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/lc3_arb_starve_cnt.sv
// Counts back-to-back data grants taken while a fetch waits; flags when the
// fetch must be served next.
module lc3_arb_starve_cnt
  import lc3_arb_pkg::*;
#(
  parameter int unsigned MAX_DBURST = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_macc_i,
  input  logic grant_i_entry_i,
  input  logic grant_d_entry_i,
  output logic dburst_full_o
);

  logic [DBURST_W-1:0] dburst_q, dburst_d;
  logic                full_q;

  // Clear whenever no fetch is waiting or the fetch wins; saturate at the limit.
  always_comb begin
    dburst_d = dburst_q;
    if (!i_macc_i || grant_i_entry_i) begin
      dburst_d = '0;
    end else if (grant_d_entry_i && (dburst_q < DBURST_W'(MAX_DBURST))) begin
      dburst_d = dburst_q + DBURST_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dburst_q <= '0;
      full_q   <= 1'b0;
    end else begin
      dburst_q <= dburst_d;
      full_q   <= (dburst_d >= DBURST_W'(MAX_DBURST));
    end
  end

  assign dburst_full_o = full_q;

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Arbitrates one single-port memory between LC3 instruction fetch and data
// accesses; data has priority, bounded by a burst limit.
module lc3_mem_arbiter
  import lc3_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MAX_DBURST  = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              I_macc,
  input  logic              instrmem_rd,
  input  logic [ADDR_W-1:0] pc,
  output logic              complete_instr,
  output logic [DATA_W-1:0] Instr_dout,
  input  logic              D_macc,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic              complete_data,
  output logic [DATA_W-1:0] Data_dout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err_timeout
);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cmpl_i_q, cmpl_i_d;
  logic                cmpl_d_q, cmpl_d_d;
  logic [DATA_W-1:0]   instr_dout_q, instr_dout_d;
  logic [DATA_W-1:0]   data_dout_q, data_dout_d;
  logic                err_q, err_d;

  logic                i_valid_c;
  logic                dburst_full_c;
  logic                i_must_win_c;
  logic                in_grant_c;
  logic                timeout_c;
  logic                grant_i_entry_c;
  logic                grant_d_entry_c;
  logic [DATA_W-1:0]   resp_data_c;

  assign i_valid_c       = I_macc && instrmem_rd;
  assign i_must_win_c    = i_valid_c && dburst_full_c;
  assign in_grant_c      = (state_q == GRANT_I) || (state_q == GRANT_D);
  assign timeout_c       = in_grant_c && !mem_ack &&
                           (tcnt_q == TCNT_W'(MEM_TIMEOUT - 1));
  assign grant_i_entry_c = (state_q == IDLE) && (state_d == GRANT_I);
  assign grant_d_entry_c = (state_q == IDLE) && (state_d == GRANT_D);
  assign resp_data_c     = timeout_c ? DATA_W'(ABORT_DATA) : mem_rdata;

  lc3_arb_starve_cnt #(
    .MAX_DBURST (MAX_DBURST)
  ) u_starve (
    .clk_i           (clock),
    .rst_ni          (reset),
    .i_macc_i        (I_macc),
    .grant_i_entry_i (grant_i_entry_c),
    .grant_d_entry_i (grant_d_entry_c),
    .dburst_full_o   (dburst_full_c)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (D_macc && !i_must_win_c) begin
          state_d = GRANT_D;
        end else if (i_valid_c) begin
          state_d = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ack || timeout_c) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values, all registered below.
  always_comb begin
    owner_d      = owner_q;
    tcnt_d       = tcnt_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cmpl_i_d     = 1'b0;
    cmpl_d_d     = 1'b0;
    instr_dout_d = instr_dout_q;
    data_dout_d  = data_dout_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (grant_d_entry_c) begin
          owner_d     = OWN_D;
          tcnt_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = !Data_rd;
          mem_addr_d  = Data_addr;
          mem_wdata_d = Data_din;
        end else if (grant_i_entry_c) begin
          owner_d    = OWN_I;
          tcnt_d     = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc;
        end
      end
      GRANT_I, GRANT_D: begin
        if (state_d == RESP) begin
          err_d = err_q | timeout_c;
          if (owner_q == OWN_D) begin
            cmpl_d_d = 1'b1;
            if (!mem_we_q) begin
              data_dout_d = resp_data_c;
            end
          end else begin
            cmpl_i_d     = 1'b1;
            instr_dout_d = resp_data_c;
          end
        end else begin
          mem_req_d = 1'b1;
          tcnt_d    = tcnt_q + TCNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath / output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q      <= OWN_I;
      tcnt_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cmpl_i_q     <= 1'b0;
      cmpl_d_q     <= 1'b0;
      instr_dout_q <= '0;
      data_dout_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      tcnt_q       <= tcnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cmpl_i_q     <= cmpl_i_d;
      cmpl_d_q     <= cmpl_d_d;
      instr_dout_q <= instr_dout_d;
      data_dout_q  <= data_dout_d;
      err_q        <= err_d;
    end
  end

  assign complete_instr = cmpl_i_q;
  assign complete_data  = cmpl_d_q;
  assign Instr_dout     = instr_dout_q;
  assign Data_dout      = data_dout_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed self-checking bench for lc3_mem_arbiter.
module tb_lc3_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_macc, instrmem_rd, D_macc, Data_rd, mem_ack;
  logic [15:0] pc, Data_addr, Data_din, mem_rdata;
  logic        complete_instr, complete_data, mem_req, mem_we, err_timeout;
  logic [15:0] Instr_dout, Data_dout, mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  lc3_mem_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .I_macc         (I_macc),
    .instrmem_rd    (instrmem_rd),
    .pc             (pc),
    .complete_instr (complete_instr),
    .Instr_dout     (Instr_dout),
    .D_macc         (D_macc),
    .Data_rd        (Data_rd),
    .Data_addr      (Data_addr),
    .Data_din       (Data_din),
    .complete_data  (complete_data),
    .Data_dout      (Data_dout),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .err_timeout    (err_timeout)
  );

  always #5 clock = ~clock;

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({mem_req, mem_we, complete_instr, complete_data, err_timeout} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {mem_req, mem_we, complete_instr, complete_data, err_timeout});
    end
    n_cmp++;
    if ({Instr_dout, Data_dout, mem_addr, mem_wdata} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected 0",
               {Instr_dout, Data_dout, mem_addr, mem_wdata});
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_req: got %b expected 0", mem_req);
    end
  endtask

  task automatic test_single_read;
    I_macc = 1'b1; instrmem_rd = 1'b1; pc = 16'h3000;
    @(negedge clock);
    n_cmp++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h3000}) begin
      n_bad++;
      $display("FAIL read_grant: got req=%b we=%b addr=%h expected 1 0 3000",
               mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    @(negedge clock);
    n_cmp++;
    if ({complete_instr, complete_data, mem_req, Instr_dout} !== {3'b100, 16'h1234}) begin
      n_bad++;
      $display("FAIL read_complete: got ci=%b cd=%b req=%b dout=%h expected 1 0 0 1234",
               complete_instr, complete_data, mem_req, Instr_dout);
    end
    I_macc = 1'b0; mem_ack = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({complete_instr, mem_req, Instr_dout} !== {2'b00, 16'h1234}) begin
      n_bad++;
      $display("FAIL read_pulse_end: got ci=%b req=%b dout=%h expected 0 0 1234",
               complete_instr, mem_req, Instr_dout);
    end
  endtask

  task automatic test_ignored_fetch;
    logic seen;
    seen = 1'b0;
    I_macc = 1'b1; instrmem_rd = 1'b0; pc = 16'h3010;
    repeat (3) begin
      @(negedge clock);
      seen = seen | mem_req | complete_instr;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL ignored_fetch: got activity=%b expected 0", seen);
    end
    I_macc = 1'b0; instrmem_rd = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_collision;
    I_macc = 1'b1; instrmem_rd = 1'b1; pc = 16'h3002;
    D_macc = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4000;
    @(negedge clock);
    n_cmp++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'h4000}) begin
      n_bad++;
      $display("FAIL coll_data_first: got req=%b we=%b addr=%h expected 1 0 4000",
               mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 16'h5678;
    @(negedge clock);
    n_cmp++;
    if ({complete_data, complete_instr, Data_dout} !== {2'b10, 16'h5678}) begin
      n_bad++;
      $display("FAIL coll_data_done: got cd=%b ci=%b dout=%h expected 1 0 5678",
               complete_data, complete_instr, Data_dout);
    end
    D_macc = 1'b0; mem_ack = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({mem_req, complete_data} !== 2'b00) begin
      n_bad++;
      $display("FAIL coll_idle: got req=%b cd=%b expected 0 0", mem_req, complete_data);
    end
    @(negedge clock);
    n_cmp++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'h3002}) begin
      n_bad++;
      $display("FAIL coll_instr_grant: got req=%b we=%b addr=%h expected 1 0 3002",
               mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 16'h9ABC;
    @(negedge clock);
    n_cmp++;
    if ({complete_instr, Instr_dout, Data_dout} !== {1'b1, 16'h9ABC, 16'h5678}) begin
      n_bad++;
      $display("FAIL coll_instr_done: got ci=%b idout=%h ddout=%h expected 1 9abc 5678",
               complete_instr, Instr_dout, Data_dout);
    end
    I_macc = 1'b0; mem_ack = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_starvation;
    int  n_dg, n_cd;
    logic got_i, done;
    n_dg = 0; n_cd = 0; got_i = 1'b0; done = 1'b0;
    I_macc = 1'b1; instrmem_rd = 1'b1; pc = 16'h3004;
    D_macc = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4010; mem_rdata = 16'h0F0F;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock);
      if (complete_data) n_cd++;
      if (complete_instr) begin
        done = 1'b1;
        I_macc = 1'b0;
      end
      if (mem_req) begin
        if (mem_addr == 16'h4010) begin
          n_dg++;
        end else if (mem_addr == 16'h3004) begin
          got_i = 1'b1;
          D_macc = 1'b0;
          mem_rdata = 16'h7777;
        end
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0; I_macc = 1'b0; D_macc = 1'b0;
    n_cmp++;
    if (n_dg != 4) begin
      n_bad++;
      $display("FAIL starve_data_grants: got %0d expected 4", n_dg);
    end
    n_cmp++;
    if (n_cd != 4) begin
      n_bad++;
      $display("FAIL starve_data_completes: got %0d expected 4", n_cd);
    end
    n_cmp++;
    if ({got_i, done} !== 2'b11) begin
      n_bad++;
      $display("FAIL starve_instr_served: got grant=%b done=%b expected 1 1", got_i, done);
    end
    n_cmp++;
    if ({Instr_dout, Data_dout} !== {16'h7777, 16'h0F0F}) begin
      n_bad++;
      $display("FAIL starve_dout: got %h expected 77770f0f", {Instr_dout, Data_dout});
    end
    @(negedge clock);
  endtask

  task automatic test_write;
    D_macc = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4020; Data_din = 16'hBEEF;
    mem_rdata = 16'hFFFF;
    @(negedge clock);
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h4020, 16'hBEEF}) begin
      n_bad++;
      $display("FAIL write_grant: got req=%b we=%b addr=%h wdata=%h expected 1 1 4020 beef",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clock);
    n_cmp++;
    if ({mem_req, complete_data} !== 2'b10) begin
      n_bad++;
      $display("FAIL write_wait: got req=%b cd=%b expected 1 0", mem_req, complete_data);
    end
    @(negedge clock);
    mem_ack = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({complete_data, mem_req, Data_dout, err_timeout} !== {2'b10, 16'h0F0F, 1'b0}) begin
      n_bad++;
      $display("FAIL write_complete: got cd=%b req=%b dout=%h err=%b expected 1 0 0f0f 0",
               complete_data, mem_req, Data_dout, err_timeout);
    end
    D_macc = 1'b0; mem_ack = 1'b0; Data_rd = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_timeout;
    int   n_gc;
    logic done;
    n_gc = 0; done = 1'b0;
    D_macc = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4030; mem_ack = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (complete_data) done = 1'b1;
      else if (mem_req) n_gc++;
    end
    D_macc = 1'b0;
    n_cmp++;
    if ({done, n_gc[7:0]} !== {1'b1, 8'd15}) begin
      n_bad++;
      $display("FAIL timeout_cycles: got done=%b grant_cycles=%0d expected 1 15", done, n_gc);
    end
    n_cmp++;
    if ({Data_dout, err_timeout} !== {16'hDEAD, 1'b1}) begin
      n_bad++;
      $display("FAIL timeout_abort: got dout=%h err=%b expected dead 1", Data_dout, err_timeout);
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({err_timeout, complete_data, mem_req} !== 3'b100) begin
      n_bad++;
      $display("FAIL timeout_sticky: got err=%b cd=%b req=%b expected 1 0 0",
               err_timeout, complete_data, mem_req);
    end
  endtask

  task automatic test_reset_mid_grant;
    logic seen;
    seen = 1'b0;
    D_macc = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4040; mem_ack = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_grant: got req=%b expected 1", mem_req);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, err_timeout, complete_data, Data_dout} !== {3'b000, 16'h0000}) begin
      n_bad++;
      $display("FAIL rst_async_clear: got req=%b err=%b cd=%b dout=%h expected 0 0 0 0000",
               mem_req, err_timeout, complete_data, Data_dout);
    end
    @(negedge clock);
    reset = 1'b1; D_macc = 1'b0;
    repeat (3) begin
      @(negedge clock);
      seen = seen | complete_data | complete_instr | mem_req;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_complete: got activity=%b expected 0", seen);
    end
    I_macc = 1'b1; instrmem_rd = 1'b1; pc = 16'h3100;
    @(negedge clock);
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h3100}) begin
      n_bad++;
      $display("FAIL rst_regrant: got req=%b addr=%h expected 1 3100", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 16'hABCD;
    @(negedge clock);
    n_cmp++;
    if ({complete_instr, Instr_dout} !== {1'b1, 16'hABCD}) begin
      n_bad++;
      $display("FAIL rst_refetch: got ci=%b dout=%h expected 1 abcd", complete_instr, Instr_dout);
    end
    I_macc = 1'b0; mem_ack = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    I_macc = 1'b0; instrmem_rd = 1'b0; pc = '0;
    D_macc = 1'b0; Data_rd = 1'b1; Data_addr = '0; Data_din = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_single_read();
    test_ignored_fetch();
    test_collision();
    test_starvation();
    test_write();
    test_timeout();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
